// File: rtl/rgb_fade_sequencer_pkg.sv
// Shared definitions for the RGB keyframe fade sequencer: FSM states,
// colour field positions inside a 24-bit key word and PWM resolution.
package rgb_fade_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FADE = 2'd2
  } fade_state_t;

  localparam int PWM_BITS = 8;
  localparam int RGB_W    = 24;

  localparam int R_MSB = 23;
  localparam int R_LSB = 16;
  localparam int G_MSB = 15;
  localparam int G_LSB = 8;
  localparam int B_MSB = 7;
  localparam int B_LSB = 0;

  // Move one count toward the target; holds once equal, so it can never wrap.
  function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
    logic [PWM_BITS-1:0] nxt;
    nxt = cur;
    if (cur < tgt) begin
      nxt = cur + PWM_BITS'(1);
    end else if (cur > tgt) begin
      nxt = cur - PWM_BITS'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Three-channel 8-bit PWM stage. One free-running counter is shared by all
// channels; each duty is copied into a shadow register only at counter wrap
// so a duty change mid-period can never produce a runt pulse.
module rgb_pwm
  import rgb_fade_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty_r,
  input  logic [PWM_BITS-1:0] duty_g,
  input  logic [PWM_BITS-1:0] duty_b,
  output logic                red,
  output logic                green,
  output logic                blue
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] shadow_r;
  logic [PWM_BITS-1:0] shadow_g;
  logic [PWM_BITS-1:0] shadow_b;
  logic                at_wrap;

  assign at_wrap = (pwm_cnt == {PWM_BITS{1'b1}});

  // Free-running period counter, wraps naturally every 256 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Latch new duties only on the last count so each period uses one value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= '0;
      shadow_g <= '0;
      shadow_b <= '0;
    end else if (at_wrap) begin
      shadow_r <= duty_r;
      shadow_g <= duty_g;
      shadow_b <= duty_b;
    end
  end

  // Registered compare: high for exactly `duty` counts of every period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else begin
      red   <= (pwm_cnt < shadow_r);
      green <= (pwm_cnt < shadow_g);
      blue  <= (pwm_cnt < shadow_b);
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Keyframe colour sequencer for the RGB LED. A programmable table of RGB
// targets is walked key by key; the live duties ramp linearly toward each
// target one count per step tick, then the PWM stage drives the pins.
module rgb_fade_sequencer
  import rgb_fade_sequencer_pkg::*;
#(
  parameter int STEP_DIV = 1 << 20,
  parameter int N_KEYS   = 8,
  parameter int KEY_AW   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [KEY_AW:0]   n_keys,
  input  logic              key_we,
  input  logic [KEY_AW-1:0] key_addr,
  input  logic [RGB_W-1:0]  key_data,
  output logic              red,
  output logic              green,
  output logic              blue,
  output logic              busy,
  output logic              done,
  output logic [KEY_AW-1:0] key_idx
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [KEY_AW:0]  KEYS_MAX  = (KEY_AW + 1)'(N_KEYS);

  fade_state_t          state_q;
  fade_state_t          state_d;
  logic [RGB_W-1:0]     key_table [N_KEYS];
  logic [RGB_W-1:0]     target_q;
  logic [PWM_BITS-1:0]  duty_r;
  logic [PWM_BITS-1:0]  duty_g;
  logic [PWM_BITS-1:0]  duty_b;
  logic [CNT_W-1:0]     step_cnt;
  logic [KEY_AW-1:0]    key_idx_q;
  logic                 done_q;

  logic [KEY_AW:0]      n_eff;
  logic                 last_key;
  logic                 all_eq;
  logic                 step_tick;
  logic                 start_seq;
  logic                 advance;
  logic                 finish;

  // Requests beyond the table depth are clamped rather than rejected.
  assign n_eff     = (n_keys > KEYS_MAX) ? KEYS_MAX : n_keys;
  assign last_key  = (({1'b0, key_idx_q} + (KEY_AW + 1)'(1)) >= n_eff);
  assign all_eq    = (duty_r == target_q[R_MSB:R_LSB]) &&
                     (duty_g == target_q[G_MSB:G_LSB]) &&
                     (duty_b == target_q[B_MSB:B_LSB]);
  assign step_tick = (state_q == FADE) && (step_cnt == STEP_LAST);

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign key_idx = key_idx_q;

  // Keyframe table: writable at any time, read only during LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEYS; i++) begin
        key_table[i] <= '0;
      end
    end else if (key_we) begin
      key_table[key_addr] <= key_data;
    end
  end

  // Sequencer next-state: stop overrides everything, including a same-cycle start.
  always_comb begin
    state_d   = state_q;
    start_seq = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (n_eff != '0)) begin
            state_d   = LOAD;
            start_seq = 1'b1;
          end
        end
        LOAD: begin
          state_d = FADE;
        end
        FADE: begin
          if (all_eq) begin
            if (last_key && !loop) begin
              state_d = IDLE;
              finish  = 1'b1;
            end else begin
              state_d = LOAD;
              advance = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Key pointer and completion pulse; the pointer is left on the last key at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= finish;
      if (start_seq) begin
        key_idx_q <= '0;
      end else if (advance) begin
        key_idx_q <= last_key ? '0 : key_idx_q + KEY_AW'(1);
      end
    end
  end

  // Target capture: a table write to the active key is only seen at its next LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
    end else if (state_q == LOAD) begin
      target_q <= key_table[key_idx_q];
    end
  end

  // Step divider: restarts on every LOAD so each key gets a full first interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (state_q == LOAD) begin
      step_cnt <= '0;
    end else if (state_q == FADE) begin
      step_cnt <= step_tick ? '0 : step_cnt + CNT_W'(1);
    end
  end

  // Per-channel linear stepper; a stop in the same cycle freezes the colour as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_r <= '0;
      duty_g <= '0;
      duty_b <= '0;
    end else if (step_tick && !all_eq && !stop) begin
      duty_r <= step_toward(duty_r, target_q[R_MSB:R_LSB]);
      duty_g <= step_toward(duty_g, target_q[G_MSB:G_LSB]);
      duty_b <= step_toward(duty_b, target_q[B_MSB:B_LSB]);
    end
  end

  rgb_pwm u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .duty_r (duty_r),
    .duty_g (duty_g),
    .duty_b (duty_b),
    .red    (red),
    .green  (green),
    .blue   (blue)
  );

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench for rgb_fade_sequencer with a fast step divider.
// Expected timing and colours come from a key-level model: each key costs
// LOAD + one equality cycle + STEP_DIV cycles per count of the largest
// channel distance, and the final colour is the last key's target.
module tb_rgb_fade_sequencer;

  localparam int STEP_DIV = 4;
  localparam int N_KEYS   = 8;
  localparam int KEY_AW   = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic              loop;
  logic [KEY_AW:0]   n_keys;
  logic              key_we;
  logic [KEY_AW-1:0] key_addr;
  logic [23:0]       key_data;
  logic              red;
  logic              green;
  logic              blue;
  logic              busy;
  logic              done;
  logic [KEY_AW-1:0] key_idx;

  rgb_fade_sequencer #(
    .STEP_DIV (STEP_DIV),
    .N_KEYS   (N_KEYS),
    .KEY_AW   (KEY_AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .n_keys   (n_keys),
    .key_we   (key_we),
    .key_addr (key_addr),
    .key_data (key_data),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .busy     (busy),
    .done     (done),
    .key_idx  (key_idx)
  );

  always #5 clk = ~clk;

  logic [23:0] live_duty;
  assign live_duty = {dut.duty_r, dut.duty_g, dut.duty_b};

  int          vectors_applied = 0;
  int          miscompares     = 0;
  logic [23:0] model_table [N_KEYS];
  logic [23:0] model_duty;

  typedef struct {
    logic [23:0] key;
    int          exp_lat;
    logic [23:0] exp_final;
    int          exp_red_high;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int keyTicks(input logic [23:0] a, input logic [23:0] b);
    int m;
    int x;
    int y;
    int d;
    m = 0;
    for (int ch = 0; ch < 3; ch++) begin
      x = int'(a[ch*8 +: 8]);
      y = int'(b[ch*8 +: 8]);
      d = (x > y) ? x - y : y - x;
      if (d > m) m = d;
    end
    return m;
  endfunction

  function automatic int predictLatency(input logic [23:0] from, input int n_req);
    int          n;
    int          lat;
    logic [23:0] cur;
    n   = (n_req > N_KEYS) ? N_KEYS : n_req;
    lat = 1;
    cur = from;
    for (int k = 0; k < n; k++) begin
      lat += STEP_DIV * keyTicks(cur, model_table[k]) + 2;
      cur = model_table[k];
    end
    return lat;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    loop     = 1'b0;
    n_keys   = '0;
    key_we   = 1'b0;
    key_addr = '0;
    key_data = '0;
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < N_KEYS; i++) model_table[i] = '0;
    model_duty = '0;
    tick(1);
  endtask

  task automatic writeKey(input logic [KEY_AW-1:0] addr, input logic [23:0] data);
    key_we   = 1'b1;
    key_addr = addr;
    key_data = data;
    tick(1);
    key_we = 1'b0;
    model_table[addr] = data;
  endtask

  task automatic applyStimulus(input logic [KEY_AW:0] nk, input logic lp,
                               input int budget, output int lat);
    n_keys = nk;
    loop   = lp;
    start  = 1'b1;
    tick(1);
    start = 1'b0;
    lat   = 1;
    checkOutput("busy_after_start", busy, 1);
    while (done !== 1'b1 && lat < budget) begin
      tick(1);
      lat++;
    end
    if (done === 1'b1) begin
      checkOutput("busy_at_done", busy, 0);
      tick(1);
      checkOutput("done_one_cycle", done, 0);
    end
  endtask

  task automatic countHigh(input int ch, input int ncyc, output int cnt);
    cnt = 0;
    repeat (ncyc) begin
      tick(1);
      case (ch)
        0:       cnt += int'(red);
        1:       cnt += int'(green);
        default: cnt += int'(blue);
      endcase
    end
  endtask

  task automatic checkPwm(input string name, input int ch, input int expected);
    int c;
    tick(260);
    countHigh(ch, 256, c);
    checkOutput(name, c, expected);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    int          exp;
    int          neff;
    int          w;
    int          green_high;
    int          busy_seen;
    int          done_seen;
    int          bticks;
    logic [23:0] k;
    logic [23:0] prev;
    logic [23:0] mid_duty;
    logic [KEY_AW-1:0] prev_idx;
    int          change_cyc [$];
    int          change_val [$];
    logic [23:0] change_duty [$];
    int          exp_cyc [3];
    int          exp_val [3];
    logic [23:0] exp_dut [3];

    vecs[0] = '{24'h000000,  3, 24'h000000,  0};
    vecs[1] = '{24'h050302, 23, 24'h050302,  5};
    vecs[2] = '{24'h050302,  3, 24'h050302,  5};
    vecs[3] = '{24'h020507, 23, 24'h020507,  2};
    vecs[4] = '{24'h000000, 31, 24'h000000,  0};
    vecs[5] = '{24'h0A0A0A, 43, 24'h0A0A0A, 10};
    vecs[6] = '{24'h0B0000, 43, 24'h0B0000, 11};

    doReset();
    checkOutput("reset_outputs", {red, green, blue, busy, done, key_idx}, 0);
    checkOutput("reset_duty", live_duty, 0);

    // Reset asserted mid-fade, then the table must read back as all zero.
    writeKey(0, 24'hFF0000);
    n_keys = 1;
    loop   = 1'b0;
    start  = 1'b1;
    tick(1);
    start = 1'b0;
    tick(100);
    checkOutput("midfade_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    checkOutput("async_reset_outputs", {red, green, blue, busy, done, key_idx}, 0);
    checkOutput("async_reset_duty", live_duty, 0);
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < N_KEYS; i++) model_table[i] = '0;
    model_duty = '0;
    tick(1);
    exp = predictLatency(model_duty, N_KEYS);
    applyStimulus(N_KEYS, 1'b0, exp + 50, lat);
    checkOutput("zero_table_latency", lat, exp);
    checkOutput("zero_table_duty", live_duty, 0);

    // Full red ramp on a single key.
    writeKey(0, 24'hFF0000);
    exp = predictLatency(model_duty, 1);
    applyStimulus(1, 1'b0, exp + 80, lat);
    checkOutput("red_ramp_latency", lat, exp);
    checkOutput("red_ramp_duty", live_duty, 24'hFF0000);
    model_duty = 24'hFF0000;
    checkPwm("red_pwm_255", 0, 255);
    checkPwm("green_pwm_0", 1, 0);

    // Two looping keys: pointer sequence, crossfade symmetry, no done.
    doReset();
    writeKey(0, 24'h800000);
    writeKey(1, 24'h000080);
    n_keys = 2;
    loop   = 1'b1;
    start  = 1'b1;
    tick(1);
    start     = 1'b0;
    prev_idx  = key_idx;
    done_seen = 0;
    mid_duty  = '0;
    exp_cyc[0] = 1 + STEP_DIV * 128 + 2;
    exp_cyc[1] = exp_cyc[0] + STEP_DIV * 128 + 2;
    exp_cyc[2] = exp_cyc[1] + STEP_DIV * 128 + 2;
    exp_val    = '{1, 0, 1};
    exp_dut    = '{24'h800000, 24'h000080, 24'h800000};
    for (int c = 1; c <= 1600; c++) begin
      if (key_idx != prev_idx) begin
        change_cyc.push_back(c);
        change_val.push_back(int'(key_idx));
        change_duty.push_back(live_duty);
        prev_idx = key_idx;
      end
      if (done === 1'b1) done_seen++;
      if (c == 700) mid_duty = live_duty;
      tick(1);
    end
    checkOutput("loop_key_changes", change_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < change_cyc.size()) begin
        checkOutput($sformatf("loop_change%0d_cycle", i), change_cyc[i], exp_cyc[i]);
        checkOutput($sformatf("loop_change%0d_idx", i), change_val[i], exp_val[i]);
        checkOutput($sformatf("loop_change%0d_duty", i), change_duty[i], exp_dut[i]);
      end
    end
    bticks = (700 - exp_cyc[0] - 1) / STEP_DIV;
    if (bticks > 128) bticks = 128;
    checkOutput("crossfade_mid", mid_duty, {8'(128 - bticks), 8'h00, 8'(bticks)});
    checkOutput("loop_no_done", done_seen, 0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    checkOutput("loop_stop_busy", busy, 0);

    // Stop mid-fade freezes the colour; stop beats a simultaneous start.
    doReset();
    writeKey(0, 24'hFF0000);
    n_keys = 1;
    start  = 1'b1;
    tick(1);
    start = 1'b0;
    w = 0;
    while (dut.duty_r != 8'd40 && w < 400) begin
      tick(1);
      w++;
    end
    checkOutput("reach_red_40", dut.duty_r, 40);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    checkOutput("stop_busy", busy, 0);
    checkOutput("stop_no_done", done, 0);
    checkOutput("stop_duty", live_duty, 24'h280000);
    tick(300);
    checkOutput("stop_duty_held", live_duty, 24'h280000);
    countHigh(0, 256, w);
    checkOutput("stop_red_pwm_40", w, 40);
    model_duty = 24'h280000;
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("start_stop_busy", busy, 0);
    tick(3);
    checkOutput("start_stop_busy_later", busy, 0);

    // Key already at the live colour, then a zero-length request.
    writeKey(0, 24'h280000);
    exp = predictLatency(model_duty, 1);
    applyStimulus(1, 1'b0, exp + 20, lat);
    checkOutput("equal_key_latency", lat, exp);
    checkOutput("equal_key_duty", live_duty, 24'h280000);
    n_keys = 0;
    start  = 1'b1;
    tick(1);
    start     = 1'b0;
    busy_seen = int'(busy);
    repeat (5) begin
      tick(1);
      busy_seen += int'(busy);
    end
    checkOutput("zero_keys_busy", busy_seen, 0);

    // Table writes during a fade: active key unchanged, next key picks up the write.
    doReset();
    writeKey(0, 24'h000010);
    writeKey(1, 24'h000030);
    n_keys = 2;
    loop   = 1'b0;
    start  = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10);
    writeKey(0, 24'h0000FF);
    writeKey(1, 24'h100018);
    exp = 1 + (STEP_DIV * keyTicks(24'h000000, 24'h000010) + 2)
            + (STEP_DIV * keyTicks(24'h000010, 24'h100018) + 2);
    lat = 13;
    green_high = 0;
    while (done !== 1'b1 && lat < 300) begin
      green_high += int'(green);
      tick(1);
      lat++;
    end
    checkOutput("midfade_write_latency", lat, exp);
    checkOutput("midfade_write_duty", live_duty, 24'h100018);
    checkOutput("green_never_high", green_high, 0);
    model_duty = 24'h100018;

    // Table-driven single-key fades, each starting from the previous colour.
    doReset();
    for (int v = 0; v < 7; v++) begin
      writeKey(0, vecs[v].key);
      applyStimulus(1, 1'b0, vecs[v].exp_lat + 50, lat);
      checkOutput($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      checkOutput($sformatf("vec%0d_duty", v), live_duty, vecs[v].exp_final);
      checkPwm($sformatf("vec%0d_red_pwm", v), 0, vecs[v].exp_red_high);
      model_duty = vecs[v].key;
    end

    // Randomised multi-key runs, including requests above the table depth.
    for (int it = 0; it < 6; it++) begin
      prev = model_duty;
      for (int kk = 0; kk < N_KEYS; kk++) begin
        if (kk > 0 && $urandom_range(0, 3) == 0) begin
          k = prev;
        end else begin
          k = {8'($urandom_range(0, 24)), 8'($urandom_range(0, 24)),
               8'($urandom_range(0, 24))};
        end
        writeKey(KEY_AW'(kk), k);
        prev = k;
      end
      w    = $urandom_range(1, 15);
      neff = (w > N_KEYS) ? N_KEYS : w;
      exp  = predictLatency(model_duty, w);
      applyStimulus((KEY_AW + 1)'(w), 1'b0, exp + 50, lat);
      checkOutput($sformatf("rand%0d_latency", it), lat, exp);
      checkOutput($sformatf("rand%0d_duty", it), live_duty, model_table[neff-1]);
      checkOutput($sformatf("rand%0d_key_idx", it), key_idx, neff - 1);
      model_duty = model_table[neff-1];
      checkPwm($sformatf("rand%0d_blue_pwm", it), 2, int'(model_duty[7:0]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
